i2s_dac_transmitter: RTL and testbench
======================================

Name: i2s_dac_transmitter

Overview:
- Serializes stereo PCM samples from the pitch-shift datapath onto the WM8731 DAC serial line (DACDAT).
- This is the transmit-direction counterpart of the ADC capture path.
- Codec is bus master: BCLK and DACLRCK are inputs; this block only drives DACDAT.
- A small pair FIFO decouples the datapath sample rate from the codec frame timing. Sits between the pitch-shift core and the audio external interface.

Parameters:
- DATA_W, 24: bits per channel word, sent MSB first.
- FIFO_DEPTH, 4: stereo pairs buffered; power of two, 2..16.

Ports:
- clk  in  1  system clock; must be at least 8x BCLK.
- reset  in  1  synchronous, active-high.
- bclk  in  1  codec bit clock; asynchronous to clk.
- daclrck  in  1  codec DAC frame clock; asynchronous to clk; 0 = left, 1 = right.
- left_data  in  DATA_W  left sample, two's complement.
- right_data  in  DATA_W  right sample, two's complement.
- sample_valid  in  1  pair valid.
- sample_ready  out  1  FIFO can accept a pair.
- dacdat  out  1  serial DAC data.
- underflow  out  1  one-clk pulse when a frame starts with the FIFO empty.
- fifo_level  out  log2(FIFO_DEPTH)+1  pairs currently stored.

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-high; clock port `clk`, reset port `reset`.
- Reset values:
  - dacdat=0, underflow=0, fifo_level=0, sample_ready=0 while reset is high; sample_ready=1 from the first cycle after reset.
  - FIFO emptied; shift register=0; FSM=WAIT_SYNC.
  - Reset mid-word: dacdat goes to 0 on the next clk; the in-flight word is abandoned.
- Synchronization:
  - bclk and daclrck each pass through 2 flops (s1, s2), plus a history flop s3.
  - BCLK falling edge (fe) = s3_bclk & ~s2_bclk.
  - All serial activity happens only on cycles where fe=1.
  - dacdat is registered and changes on the clk edge that ends the fe cycle, i.e. 3 clk edges after the pin edge (+1 for sampling phase).
- LRCK tracking: on each fe, lr_now = s2_lrck and lr_prev <= lr_now. A change is detected when lr_now != lr_prev.
- FSM states and transitions:
  - WAIT_SYNC: dacdat=0. Leave only on an fe where lrck changes 1->0 (start of left frame); go to LOAD_L.
  - LOAD_L (taken at that same fe):
    - If FIFO non-empty: pop one pair; shift = left; latch right into hold; bit_cnt = DATA_W.
    - If FIFO empty: shift = 0, hold = 0, underflow pulses for 1 clk.
    - dacdat is unchanged at this fe (I2S one-bit delay). Go to SHIFT_L.
  - SHIFT_L: each fe with bit_cnt > 0: dacdat = shift[MSB], shift <<= 1, bit_cnt--. Each fe with bit_cnt = 0: dacdat = 0. An fe with a 0->1 lrck change: shift = hold, bit_cnt = DATA_W, go to SHIFT_R; dacdat is unchanged at that fe.
  - SHIFT_R: same shifting rule. An fe with a 1->0 change performs the LOAD_L action and returns to SHIFT_L.
- Short frames: if an lrck change arrives before bit_cnt reaches 0, the remaining bits are dropped and the new word loads. No error flag.
- FIFO:
  - Push when sample_valid & sample_ready; sample_ready = (fifo_level != FIFO_DEPTH).
  - Pop occurs only in LOAD_L.
  - Push and pop in the same cycle: level unchanged, both take effect.
  - Push while empty in the same cycle as a pop attempt: the pop sees empty (no bypass), underflow fires, and the pushed pair is kept.
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_level updates one clk after the push/pop edge.
- Arithmetic: no sign extension or truncation; words are transmitted verbatim.

Test Plan:
- Reset, then push pair L=0xABCDEF, R=0x123456. Drive BCLK=clk/16 and LRCK 1->0 on a BCLK falling edge → after the first lrck low, dacdat shows nothing at the delay fe. The next 24 falling edges give 1010_1011_1100_1101_1110_1111, then 0 until LRCK rises. The right frame then gives 0x123456 with the same one-bit delay.
- Frame with FIFO empty → underflow=1 for exactly 1 clk at the left load; dacdat stays 0 for the whole frame.
- Push 5 pairs back-to-back with no frames running → sample_ready deasserts after the 4th push; fifo_level=4; the 5th pair is not accepted. After one left load: fifo_level=3, sample_ready=1.
- Push on the same clk as the left-frame pop with level=2 → fifo_level stays 2; the popped pair transmits correctly.
- LRCK toggles every 16 BCLKs with DATA_W=24 → only the top 15 bits of each word are sent after the delay slot; the next word loads cleanly with no error.
- Assert reset for 1 clk in the middle of a left word → dacdat=0 next clk; FSM returns to WAIT_SYNC. Output resumes only after the next lrck 1->0 transition, with a freshly popped pair; FIFO contents before reset are discarded (level 0).

Source files
------------

// File: rtl/i2s_dac_transmitter.sv
// I2S transmitter for the WM8731 DAC path. The codec masters BCLK/DACLRCK;
// this block buffers stereo pairs in a small FIFO and shifts each word out
// MSB first on DACDAT with the standard one-bit I2S delay after LRCK changes.
module i2s_dac_transmitter #(
    parameter int DATA_W     = 24,
    parameter int FIFO_DEPTH = 4,
    localparam int PTR_W     = $clog2(FIFO_DEPTH),
    localparam int LVL_W     = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bclk,
    input  logic              daclrck,
    input  logic [DATA_W-1:0] left_data,
    input  logic [DATA_W-1:0] right_data,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              dacdat,
    output logic              underflow,
    output logic [LVL_W-1:0]  fifo_level
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef struct packed {
        logic [DATA_W-1:0] left;
        logic [DATA_W-1:0] right;
    } pair_t;

    // The load of a new left word is an action taken on the frame-start
    // edge, not a dwell state, so only the three resting states exist.
    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        SHIFT_L   = 2'd1,
        SHIFT_R   = 2'd2
    } state_t;

    state_t             state;
    logic               s1_bclk, s2_bclk, s3_bclk;
    logic               s1_lrck, s2_lrck;
    logic               lr_prev;
    logic               fe, lr_now, lr_fall, lr_rise;
    logic [DATA_W-1:0]  shift_q;
    logic [DATA_W-1:0]  hold_q;
    logic [CNT_W-1:0]   bit_cnt;

    pair_t              mem [FIFO_DEPTH];
    pair_t              rd_pair;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic               fifo_empty, do_push, do_pop, load_l;

    // Two-flop synchronizers; s3_bclk is the history used for edge detect.
    // lr_prev (updated only on fe) acts as the LRCK history.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_bclk <= 1'b0;
            s2_bclk <= 1'b0;
            s3_bclk <= 1'b0;
            s1_lrck <= 1'b0;
            s2_lrck <= 1'b0;
        end else begin
            s1_bclk <= bclk;
            s2_bclk <= s1_bclk;
            s3_bclk <= s2_bclk;
            s1_lrck <= daclrck;
            s2_lrck <= s1_lrck;
        end
    end

    assign fe      = s3_bclk & ~s2_bclk;
    assign lr_now  = s2_lrck;
    assign lr_fall = fe & lr_prev & ~lr_now;
    assign lr_rise = fe & ~lr_prev & lr_now;

    assign fifo_empty   = (fifo_level == '0);
    assign sample_ready = ~reset & (fifo_level != LVL_W'(FIFO_DEPTH));
    assign do_push      = sample_valid & sample_ready;
    // A pair pushed on the same clk as an empty-FIFO load is not bypassed.
    assign load_l       = lr_fall;
    assign do_pop       = load_l & ~fifo_empty;
    assign rd_pair      = mem[rd_ptr];

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= '{left: left_data, right: right_data};
    end

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            fifo_level <= fifo_level + LVL_W'(do_push) - LVL_W'(do_pop);
        end
    end

    // Frame FSM and serializer; all serial activity is gated by fe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= WAIT_SYNC;
            dacdat    <= 1'b0;
            underflow <= 1'b0;
            shift_q   <= '0;
            hold_q    <= '0;
            bit_cnt   <= '0;
            lr_prev   <= 1'b0;
        end else begin
            underflow <= 1'b0;
            if (fe) begin
                lr_prev <= lr_now;
                if (load_l) begin
                    // Left frame start: dacdat holds for the I2S delay slot.
                    state   <= SHIFT_L;
                    bit_cnt <= CNT_W'(DATA_W);
                    if (!fifo_empty) begin
                        shift_q <= rd_pair.left;
                        hold_q  <= rd_pair.right;
                    end else begin
                        shift_q   <= '0;
                        hold_q    <= '0;
                        underflow <= 1'b1;
                    end
                end else begin
                    case (state)
                        SHIFT_L, SHIFT_R: begin
                            if (state == SHIFT_L && lr_rise) begin
                                // Right frame start; unsent left bits are dropped.
                                shift_q <= hold_q;
                                bit_cnt <= CNT_W'(DATA_W);
                                state   <= SHIFT_R;
                            end else if (bit_cnt != '0) begin
                                dacdat  <= shift_q[DATA_W-1];
                                shift_q <= {shift_q[DATA_W-2:0], 1'b0};
                                bit_cnt <= bit_cnt - 1'b1;
                            end else begin
                                dacdat <= 1'b0;
                            end
                        end
                        default: dacdat <= 1'b0;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_dac_transmitter.sv
// Directed bench for i2s_dac_transmitter: the bench plays codec master,
// driving BCLK at clk/16 and LRCK on BCLK falling edges, and reassembles
// the words seen on dacdat at the end of each bit period.
module tb_i2s_dac_transmitter;

    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          reset;
    logic          bclk;
    logic          daclrck;
    logic [DW-1:0] left_data;
    logic [DW-1:0] right_data;
    logic          sample_valid;
    logic          sample_ready;
    logic          dacdat;
    logic          underflow;
    logic [2:0]    fifo_level;

    int vectors     = 0;
    int miscompares = 0;
    int uf_high     = 0;

    logic [DW-1:0] lp [5] = '{24'h800001, 24'h7FFFFF, 24'h13579B, 24'h2468AC, 24'h999999};
    logic [DW-1:0] rp [5] = '{24'h000001, 24'hFFFFFE, 24'hC0FFEE, 24'hF00D42, 24'h111111};

    i2s_dac_transmitter #(.DATA_W(DW), .FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .bclk         (bclk),
        .daclrck      (daclrck),
        .left_data    (left_data),
        .right_data   (right_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .dacdat       (dacdat),
        .underflow    (underflow),
        .fifo_level   (fifo_level)
    );

    always #5 clk = ~clk;

    // Counts clk cycles with underflow high, sampled away from the active edge.
    always @(negedge clk) if (underflow === 1'b1) uf_high++;

    // One BCLK period starting at a negedge of clk: fall (with LRCK update),
    // 8 clks low, 8 clks high, then sample dacdat. An optional push lands on
    // the clk edge where the DUT acts on this falling edge.
    task automatic bit_cycle(input logic lr, input logic do_push,
                             input logic [DW-1:0] pl, input logic [DW-1:0] pr,
                             output logic d);
        bclk    = 1'b0;
        daclrck = lr;
        repeat (2) @(negedge clk);
        if (do_push) begin
            vectors++;
            if (sample_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL push_ready: got %b expected 1", sample_ready);
            end
            sample_valid = 1'b1;
            left_data    = pl;
            right_data   = pr;
        end
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (5) @(negedge clk);
        bclk = 1'b1;
        repeat (8) @(negedge clk);
        d = dacdat;
    endtask

    // One LRCK half-frame of len BCLKs; returns the delay-slot bit, the
    // (up to DW) following bits as a word, and how many later bits were 1.
    task automatic run_half(input logic lr, input int len, input logic do_push,
                            input logic [DW-1:0] pl, input logic [DW-1:0] pr,
                            output logic [DW-1:0] word, output logic slot,
                            output int tail_err);
        logic d;
        word     = '0;
        tail_err = 0;
        bit_cycle(lr, do_push, pl, pr, slot);
        for (int i = 1; i < len; i++) begin
            bit_cycle(lr, 1'b0, '0, '0, d);
            if (i <= DW) word = {word[DW-2:0], d};
            else if (d !== 1'b0) tail_err++;
        end
    endtask

    task automatic push_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
        sample_valid = 1'b1;
        left_data    = l;
        right_data   = r;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; bclk = 1'b1; daclrck = 1'b1;
        sample_valid = 1'b0; left_data = '0; right_data = '0;
        repeat (3) @(negedge clk);
        vectors += 4;
        if (dacdat !== 1'b0) begin miscompares++; $display("FAIL rst_dacdat: got %b expected 0", dacdat); end
        if (underflow !== 1'b0) begin miscompares++; $display("FAIL rst_underflow: got %b expected 0", underflow); end
        if (fifo_level !== 3'd0) begin miscompares++; $display("FAIL rst_level: got %0d expected 0", fifo_level); end
        if (sample_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready: got %b expected 0", sample_ready); end
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (sample_ready !== 1'b1) begin miscompares++; $display("FAIL post_rst_ready: got %b expected 1", sample_ready); end
    endtask

    task automatic test_basic;
        logic [DW-1:0] w;
        logic s, d;
        int t, uf0;
        push_pair(24'hABCDEF, 24'h123456);
        vectors++;
        if (fifo_level !== 3'd1) begin miscompares++; $display("FAIL basic_level1: got %0d expected 1", fifo_level); end
        uf0 = uf_high;
        bit_cycle(1'b1, 1'b0, '0, '0, d);
        bit_cycle(1'b1, 1'b0, '0, '0, d);
        run_half(1'b0, 32, 1'b0, '0, '0, w, s, t);
        vectors += 4;
        if (s !== 1'b0) begin miscompares++; $display("FAIL basic_lslot: got %b expected 0", s); end
        if (w !== 24'hABCDEF) begin miscompares++; $display("FAIL basic_left: got %h expected abcdef", w); end
        if (t != 0) begin miscompares++; $display("FAIL basic_ltail: got %0d ones expected 0", t); end
        if (fifo_level !== 3'd0) begin miscompares++; $display("FAIL basic_level0: got %0d expected 0", fifo_level); end
        run_half(1'b1, 32, 1'b0, '0, '0, w, s, t);
        vectors += 4;
        if (s !== 1'b0) begin miscompares++; $display("FAIL basic_rslot: got %b expected 0", s); end
        if (w !== 24'h123456) begin miscompares++; $display("FAIL basic_right: got %h expected 123456", w); end
        if (t != 0) begin miscompares++; $display("FAIL basic_rtail: got %0d ones expected 0", t); end
        if (uf_high != uf0) begin miscompares++; $display("FAIL basic_no_uf: got %0d expected %0d", uf_high, uf0); end
    endtask

    task automatic test_underflow;
        logic [DW-1:0] w;
        logic s;
        int t, uf0;
        uf0 = uf_high;
        run_half(1'b0, 32, 1'b0, '0, '0, w, s, t);
        vectors += 3;
        if (uf_high - uf0 != 1) begin miscompares++; $display("FAIL uf_pulse: got %0d cycles expected 1", uf_high - uf0); end
        if (w !== '0 || t != 0) begin miscompares++; $display("FAIL uf_left: got %h/%0d expected 000000/0", w, t); end
        run_half(1'b1, 32, 1'b0, '0, '0, w, s, t);
        if (w !== '0 || t != 0) begin miscompares++; $display("FAIL uf_right: got %h/%0d expected 000000/0", w, t); end
    endtask

    task automatic test_full;
        logic [4:0] rdy;
        logic [DW-1:0] w;
        logic s;
        int t;
        for (int k = 0; k < 5; k++) begin
            sample_valid = 1'b1;
            left_data    = lp[k];
            right_data   = rp[k];
            rdy[k]       = sample_ready;
            @(negedge clk);
        end
        sample_valid = 1'b0;
        vectors += 2;
        if (rdy !== 5'b01111) begin miscompares++; $display("FAIL full_ready_seq: got %b expected 01111", rdy); end
        if (fifo_level !== 3'd4) begin miscompares++; $display("FAIL full_level4: got %0d expected 4", fifo_level); end
        run_half(1'b0, 32, 1'b0, '0, '0, w, s, t);
        vectors += 3;
        if (w !== lp[0]) begin miscompares++; $display("FAIL full_left0: got %h expected %h", w, lp[0]); end
        if (fifo_level !== 3'd3) begin miscompares++; $display("FAIL full_level3: got %0d expected 3", fifo_level); end
        if (sample_ready !== 1'b1) begin miscompares++; $display("FAIL full_ready_again: got %b expected 1", sample_ready); end
        run_half(1'b1, 32, 1'b0, '0, '0, w, s, t);
        vectors++;
        if (w !== rp[0]) begin miscompares++; $display("FAIL full_right0: got %h expected %h", w, rp[0]); end
    endtask

    task automatic test_push_pop;
        logic [DW-1:0] w;
        logic s;
        int t;
        run_half(1'b0, 32, 1'b0, '0, '0, w, s, t);
        vectors += 2;
        if (w !== lp[1]) begin miscompares++; $display("FAIL pp_left1: got %h expected %h", w, lp[1]); end
        if (fifo_level !== 3'd2) begin miscompares++; $display("FAIL pp_level2: got %0d expected 2", fifo_level); end
        run_half(1'b1, 32, 1'b0, '0, '0, w, s, t);
        vectors++;
        if (w !== rp[1]) begin miscompares++; $display("FAIL pp_right1: got %h expected %h", w, rp[1]); end
        run_half(1'b0, 32, 1'b1, 24'h3C3C3C, 24'hA5A5A5, w, s, t);
        vectors += 2;
        if (w !== lp[2]) begin miscompares++; $display("FAIL pp_left2: got %h expected %h", w, lp[2]); end
        if (fifo_level !== 3'd2) begin miscompares++; $display("FAIL pp_level_same: got %0d expected 2", fifo_level); end
        run_half(1'b1, 32, 1'b0, '0, '0, w, s, t);
        vectors++;
        if (w !== rp[2]) begin miscompares++; $display("FAIL pp_right2: got %h expected %h", w, rp[2]); end
    endtask

    task automatic test_short;
        logic [DW-1:0] w, e;
        logic s;
        int t, uf0;
        uf0 = uf_high;
        run_half(1'b0, 16, 1'b0, '0, '0, w, s, t);
        e = lp[3] >> 9;
        vectors++;
        if (w !== e) begin miscompares++; $display("FAIL short_left3: got %h expected %h", w, e); end
        run_half(1'b1, 16, 1'b0, '0, '0, w, s, t);
        e = rp[3] >> 9;
        vectors++;
        if (w !== e) begin miscompares++; $display("FAIL short_right3: got %h expected %h", w, e); end
        run_half(1'b0, 16, 1'b0, '0, '0, w, s, t);
        e = 24'h3C3C3C >> 9;
        vectors++;
        if (w !== e) begin miscompares++; $display("FAIL short_left_pushed: got %h expected %h", w, e); end
        run_half(1'b1, 16, 1'b0, '0, '0, w, s, t);
        e = 24'hA5A5A5 >> 9;
        vectors += 3;
        if (w !== e) begin miscompares++; $display("FAIL short_right_pushed: got %h expected %h", w, e); end
        if (fifo_level !== 3'd0) begin miscompares++; $display("FAIL short_level0: got %0d expected 0", fifo_level); end
        if (uf_high != uf0) begin miscompares++; $display("FAIL short_no_uf: got %0d expected %0d", uf_high, uf0); end
    endtask

    task automatic test_reset_mid;
        logic [DW-1:0] w;
        logic [3:0] nib;
        logic s, d;
        int t, ones, uf0;
        push_pair(24'hF0F0F0, 24'h0F0F0F);
        push_pair(24'h111111, 24'h222222);
        bit_cycle(1'b0, 1'b0, '0, '0, d);
        nib = '0;
        for (int i = 0; i < 4; i++) begin
            bit_cycle(1'b0, 1'b0, '0, '0, d);
            nib = {nib[2:0], d};
        end
        vectors++;
        if (nib !== 4'hF || dacdat !== 1'b1) begin miscompares++; $display("FAIL rm_prefix: got %h/%b expected f/1", nib, dacdat); end
        uf0 = uf_high;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vectors += 2;
        if (dacdat !== 1'b0) begin miscompares++; $display("FAIL rm_dacdat: got %b expected 0", dacdat); end
        if (fifo_level !== 3'd0) begin miscompares++; $display("FAIL rm_level: got %0d expected 0", fifo_level); end
        ones = 0;
        for (int i = 0; i < 27; i++) begin
            bit_cycle(1'b0, 1'b0, '0, '0, d);
            if (d !== 1'b0) ones++;
        end
        run_half(1'b1, 32, 1'b0, '0, '0, w, s, t);
        vectors += 2;
        if (ones != 0 || w !== '0 || t != 0) begin miscompares++; $display("FAIL rm_silent: got %0d/%h/%0d expected 0/000000/0", ones, w, t); end
        if (uf_high != uf0) begin miscompares++; $display("FAIL rm_no_load: got %0d expected %0d", uf_high, uf0); end
        push_pair(24'h5A5A5A, 24'hC3C3C3);
        run_half(1'b0, 32, 1'b0, '0, '0, w, s, t);
        vectors += 2;
        if (w !== 24'h5A5A5A) begin miscompares++; $display("FAIL rm_left: got %h expected 5a5a5a", w); end
        if (fifo_level !== 3'd0) begin miscompares++; $display("FAIL rm_level_after: got %0d expected 0", fifo_level); end
        run_half(1'b1, 32, 1'b0, '0, '0, w, s, t);
        vectors += 2;
        if (w !== 24'hC3C3C3) begin miscompares++; $display("FAIL rm_right: got %h expected c3c3c3", w); end
        if (uf_high != uf0) begin miscompares++; $display("FAIL rm_resume_uf: got %0d expected %0d", uf_high, uf0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underflow();
        test_full();
        test_push_pop();
        test_short();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
